// File: rtl/adder_4bit_pkg.sv
// rtl/adder_4bit_pkg.sv - shared width constants and helpers for adder_4bit
package adder_4bit_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 4;

    // Carry-out is kept, so the sum is one bit wider than the operands.
    function automatic int sum_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/adder_4bit_full_adder.sv
// rtl/adder_4bit_full_adder.sv - 1-bit full-adder cell for the ripple chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_4bit.sv
// rtl/adder_4bit.sv - registered ripple-carry adder; ADDER_4BIT_CIN_EN adds a cin port
module adder_4bit
    import adder_4bit_pkg::*;
#(
    parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
`ifdef ADDER_4BIT_CIN_EN
    input  logic                         cin,
`endif
    output logic                         out_valid,
    output logic [sum_width(WIDTH)-1:0]  sum,
    output logic                         zero
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] bits;
    logic [WIDTH:0]   sum_next;

`ifdef ADDER_4BIT_CIN_EN
    assign carry[0] = cin;
`else
    assign carry[0] = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (bits[i]),
            .cout (carry[i+1])
        );
    end

    assign sum_next = {carry[WIDTH], bits};

    // Result registers load only on in_valid, so idle-cycle X on a/b never reaches them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            zero      <= 1'b1;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_next;
                zero <= (sum_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_adder_4bit.sv
// tb/tb_adder_4bit.sv - directed and exhaustive self-checking bench for adder_4bit
module tb_adder_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
`ifdef ADDER_4BIT_CIN_EN
    logic       cin;
`endif
    logic       out_valid;
    logic [4:0] sum;
    logic       zero;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
`ifdef ADDER_4BIT_CIN_EN
        .cin       (cin),
`endif
        .out_valid (out_valid),
        .sum       (sum),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv);
        in_valid = v;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [4:0] s, input logic z);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".sum"},   {27'd0, sum},       {27'd0, s});
        check({tag, ".zero"},  {31'd0, zero},      {31'd0, z});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
`ifdef ADDER_4BIT_CIN_EN
        cin      = 1'b0;
`endif

        // Reset beats a concurrent valid operation.
        drive(1'b1, 4'd5, 4'd3);
        expect_out("rst0", 1'b0, 5'b00000, 1'b1);
        drive(1'b1, 4'd5, 4'd3);
        expect_out("rst1", 1'b0, 5'b00000, 1'b1);
        rst_n = 1'b1;

        // Back-to-back basic sums.
        drive(1'b1, 4'd0, 4'd0);
        expect_out("b0+0", 1'b1, 5'b00000, 1'b1);
        drive(1'b1, 4'd1, 4'd2);
        expect_out("b1+2", 1'b1, 5'b00011, 1'b0);
        drive(1'b1, 4'd5, 4'd3);
        expect_out("b5+3", 1'b1, 5'b01000, 1'b0);
        drive(1'b1, 4'd8, 4'd7);
        expect_out("b8+7", 1'b1, 5'b01111, 1'b0);

        // Carry-out.
        drive(1'b1, 4'd15, 4'd1);
        expect_out("c15+1", 1'b1, 5'b10000, 1'b0);
        drive(1'b1, 4'd15, 4'd15);
        expect_out("c15+15", 1'b1, 5'b11110, 1'b0);

        // Hold with new and unknown operands while idle.
        drive(1'b1, 4'd5, 4'd3);
        expect_out("h5+3", 1'b1, 5'b01000, 1'b0);
        drive(1'b0, 4'd9, 4'd9);
        expect_out("hold9", 1'b0, 5'b01000, 1'b0);
        drive(1'b0, 4'bxxxx, 4'bxxxx);
        expect_out("holdx", 1'b0, 5'b01000, 1'b0);

        // Zero flag returns after a nonzero result.
        drive(1'b1, 4'd0, 4'd0);
        expect_out("z0+0", 1'b1, 5'b00000, 1'b1);

        // Exhaustive sweep; with carry-in enabled it runs with cin=1.
`ifdef ADDER_4BIT_CIN_EN
        cin = 1'b1;
`endif
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [4:0] exp_sum;
                exp_sum = 5'(i) + 5'(j);
`ifdef ADDER_4BIT_CIN_EN
                exp_sum = exp_sum + 5'd1;
`endif
                drive(1'b1, 4'(i), 4'(j));
                check("ex.sum", {27'd0, sum}, {27'd0, exp_sum});
                check("ex.valid", {31'd0, out_valid}, 32'd1);
            end
        end

        // Reset mid-stream clears outputs.
        rst_n = 1'b0;
        drive(1'b1, 4'd7, 4'd7);
        expect_out("rst2", 1'b0, 5'b00000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
